// File: rtl/dds_pkg.sv
// Shared constants for the DDS phase accumulator and quarter-wave sine path.
package dds_pkg;

  localparam int unsigned PHASE_W = 8;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned MAG_W   = 8;
  localparam int unsigned ROM_W   = 7;

  localparam logic [MAG_W-1:0] MID  = 8'd128;
  localparam logic [ROM_W-1:0] PEAK = 7'd127;

endpackage

// File: rtl/sine_quarter_rom.sv
// First quadrant of a sine wave, 64 entries of round(127*sin(pi/2*k/64)).
module sine_quarter_rom
  import dds_pkg::*;
(
  input  logic [CNT_W-1:0] idx_i,
  output logic [ROM_W-1:0] val_o
);

  always_comb begin
    val_o = '0;
    case (idx_i)
      6'd0:  val_o = 7'd0;
      6'd1:  val_o = 7'd3;
      6'd2:  val_o = 7'd6;
      6'd3:  val_o = 7'd9;
      6'd4:  val_o = 7'd12;
      6'd5:  val_o = 7'd16;
      6'd6:  val_o = 7'd19;
      6'd7:  val_o = 7'd22;
      6'd8:  val_o = 7'd25;
      6'd9:  val_o = 7'd28;
      6'd10: val_o = 7'd31;
      6'd11: val_o = 7'd34;
      6'd12: val_o = 7'd37;
      6'd13: val_o = 7'd40;
      6'd14: val_o = 7'd43;
      6'd15: val_o = 7'd46;
      6'd16: val_o = 7'd49;
      6'd17: val_o = 7'd51;
      6'd18: val_o = 7'd54;
      6'd19: val_o = 7'd57;
      6'd20: val_o = 7'd60;
      6'd21: val_o = 7'd63;
      6'd22: val_o = 7'd65;
      6'd23: val_o = 7'd68;
      6'd24: val_o = 7'd71;
      6'd25: val_o = 7'd73;
      6'd26: val_o = 7'd76;
      6'd27: val_o = 7'd78;
      6'd28: val_o = 7'd81;
      6'd29: val_o = 7'd83;
      6'd30: val_o = 7'd85;
      6'd31: val_o = 7'd88;
      6'd32: val_o = 7'd90;
      6'd33: val_o = 7'd92;
      6'd34: val_o = 7'd94;
      6'd35: val_o = 7'd96;
      6'd36: val_o = 7'd98;
      6'd37: val_o = 7'd100;
      6'd38: val_o = 7'd102;
      6'd39: val_o = 7'd104;
      6'd40: val_o = 7'd106;
      6'd41: val_o = 7'd107;
      6'd42: val_o = 7'd109;
      6'd43: val_o = 7'd111;
      6'd44: val_o = 7'd112;
      6'd45: val_o = 7'd113;
      6'd46: val_o = 7'd115;
      6'd47: val_o = 7'd116;
      6'd48: val_o = 7'd117;
      6'd49: val_o = 7'd118;
      6'd50: val_o = 7'd120;
      6'd51: val_o = 7'd121;
      6'd52: val_o = 7'd122;
      6'd53: val_o = 7'd122;
      6'd54: val_o = 7'd123;
      6'd55: val_o = 7'd124;
      6'd56: val_o = 7'd125;
      6'd57: val_o = 7'd125;
      6'd58: val_o = 7'd126;
      6'd59: val_o = 7'd126;
      6'd60: val_o = 7'd126;
      6'd61: val_o = 7'd127;
      6'd62: val_o = 7'd127;
      6'd63: val_o = 7'd127;
      default: val_o = '0;
    endcase
  end

endmodule

// File: rtl/dds_phase_sine_core.sv
// DDS core: 8-bit phase accumulator feeding a folded quarter-wave sine lookup.
// The registered sample is f(phase) of the pre-increment phase, so it lags phase_out by one cycle.
module dds_phase_sine_core
  import dds_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [PHASE_W-1:0] phase_out,
  output logic [MAG_W-1:0]   magnitude
);

  localparam logic [PHASE_W-1:0] StepInc = PHASE_W'(STEP);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [MAG_W-1:0]   mag_q, mag_d;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       quad;
  logic [CNT_W-1:0] cnt_neg;
  logic [CNT_W-1:0] rom_idx;
  logic [ROM_W-1:0] rom_val;
  logic             peak;
  logic [ROM_W-1:0] amp;
  logic [MAG_W-1:0] sample;

  assign cnt  = phase_q[CNT_W-1:0];
  assign quad = phase_q[PHASE_W-1:CNT_W];

  // Odd quadrants run the table backwards; 64-c in 6 bits is the two's complement.
  assign cnt_neg = (~cnt) + 6'd1;
  assign rom_idx = quad[0] ? cnt_neg : cnt;

  // A mirrored c==0 would alias to idx 0; it is really the top of the wave.
  assign peak = quad[0] & ~(|cnt);

  sine_quarter_rom u_rom (
    .idx_i (rom_idx),
    .val_o (rom_val)
  );

  assign amp    = peak ? PEAK : rom_val;
  assign sample = quad[1] ? (MID - {1'b0, amp}) : (MID + {1'b0, amp});

  always_comb begin
    phase_d = phase_q;
    mag_d   = mag_q;
    if (en) begin
      phase_d = phase_q + StepInc;
      mag_d   = sample;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      mag_q   <= MID;
    end else begin
      phase_q <= phase_d;
      mag_q   <= mag_d;
    end
  end

  assign phase_out = phase_q;
  assign magnitude = mag_q;

endmodule

// File: tb/tb_dds_phase_sine_core.sv
// Self-checking bench for dds_phase_sine_core: key-point vector table plus period, hold,
// async reset, STEP=64 and STEP=3 sequences.
module tb_dds_phase_sine_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en1 = 1'b0;
  logic en64 = 1'b0;
  logic en3 = 1'b0;

  logic [7:0] phase1, mag1, phase64, mag64, phase3, mag3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dds_phase_sine_core #(.STEP(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .en        (en1),
    .phase_out (phase1),
    .magnitude (mag1)
  );

  dds_phase_sine_core #(.STEP(64)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .en        (en64),
    .phase_out (phase64),
    .magnitude (mag64)
  );

  dds_phase_sine_core #(.STEP(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .en        (en3),
    .phase_out (phase3),
    .magnitude (mag3)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference sample computed from real-valued sine, independent of the RTL table.
  function automatic int rom_ref(input int k);
    real a;
    a = 3.14159265358979 / 2.0 * real'(k) / 64.0;
    return $rtoi(127.0 * $sin(a) + 0.5);
  endfunction

  function automatic int f_ref(input int p);
    int c, q, v;
    c = p % 64;
    q = p / 64;
    if ((q % 2) == 1) v = (c == 0) ? 127 : rom_ref(64 - c);
    else              v = rom_ref(c);
    return (q >= 2) ? 128 - v : 128 + v;
  endfunction

  typedef struct {
    int    phase;
    int    mag;
    string name;
  } vec_t;

  vec_t vecs[16];
  int   samp[256];
  int   seq64[4];

  initial begin
    int prev;
    int guard;

    vecs[0]  = '{0,   128, "f(0)"};
    vecs[1]  = '{1,   131, "f(1)"};
    vecs[2]  = '{2,   134, "f(2)"};
    vecs[3]  = '{16,  177, "f(16)"};
    vecs[4]  = '{32,  218, "f(32)"};
    vecs[5]  = '{63,  255, "f(63)"};
    vecs[6]  = '{64,  255, "f(64) peak"};
    vecs[7]  = '{65,  255, "f(65)"};
    vecs[8]  = '{96,  218, "f(96)"};
    vecs[9]  = '{99,  211, "f(99)"};
    vecs[10] = '{127, 131, "f(127)"};
    vecs[11] = '{128, 128, "f(128)"};
    vecs[12] = '{160, 38,  "f(160)"};
    vecs[13] = '{192, 1,   "f(192) min"};
    vecs[14] = '{224, 38,  "f(224)"};
    vecs[15] = '{255, 125, "f(255)"};
    seq64[0] = 128;
    seq64[1] = 255;
    seq64[2] = 128;
    seq64[3] = 1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset phase1", int'(phase1), 0);
    check("reset mag1", int'(mag1), 128);
    check("reset phase64", int'(phase64), 0);
    check("reset mag3", int'(mag3), 128);

    // Full period, STEP=1
    rst = 1'b0;
    en1 = 1'b1;
    prev = int'(phase1);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      samp[prev] = int'(mag1);
      check($sformatf("period phase step %0d", i), int'(phase1), (prev + 1) % 256);
      prev = int'(phase1);
    end
    check("period phase back to 0", int'(phase1), 0);

    for (int i = 0; i < 16; i++) check(vecs[i].name, samp[vecs[i].phase], vecs[i].mag);

    for (int p = 0; p < 256; p++) begin
      check($sformatf("model f(%0d)", p), samp[p], f_ref(p));
      check($sformatf("nonzero f(%0d)", p), int'(samp[p] != 0), 1);
    end
    for (int k = 1; k < 128; k++)
      check($sformatf("sym f(128+%0d)", k), samp[128 + k], 256 - samp[k]);
    for (int k = 1; k < 64; k++)
      check($sformatf("sym f(64+%0d)", k), samp[64 + k], samp[64 - k]);

    // Enable hold at phase 100
    guard = 0;
    while (phase1 != 8'd100 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("reach phase 100 in budget", int'(phase1 == 8'd100), 1);
    en1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold phase %0d", i), int'(phase1), 100);
      check($sformatf("hold mag %0d", i), int'(mag1), 211);
    end
    en1 = 1'b1;
    @(negedge clk);
    check("resume phase", int'(phase1), 101);
    check("resume mag f(100)", int'(mag1), 209);
    @(negedge clk);
    check("run phase 102", int'(phase1), 102);

    // Asynchronous reset mid-run, between edges
    #2;
    rst = 1'b1;
    #1;
    check("async rst phase", int'(phase1), 0);
    check("async rst mag", int'(mag1), 128);
    @(posedge clk);
    #1;
    check("rst held phase", int'(phase1), 0);
    check("rst held mag", int'(mag1), 128);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst phase", int'(phase1), 1);
    check("post-rst first sample", int'(mag1), 128);
    @(negedge clk);
    check("post-rst phase 2", int'(phase1), 2);
    check("post-rst sample 2", int'(mag1), 131);
    en1 = 1'b0;

    // STEP=64: four-sample period
    check("step64 idle phase", int'(phase64), 0);
    en64 = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      check($sformatf("step64 phase %0d", n), int'(phase64), (64 * (n + 1)) % 256);
      check($sformatf("step64 mag %0d", n), int'(mag64), seq64[n % 4]);
    end
    en64 = 1'b0;

    // STEP=3: 255 wraps to 2
    en3 = 1'b1;
    guard = 0;
    while (phase3 != 8'd255 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("step3 reach 255 in budget", int'(phase3 == 8'd255), 1);
    check("step3 mag f(252)", int'(mag3), 116);
    @(negedge clk);
    check("step3 wrap phase", int'(phase3), 2);
    check("step3 mag f(255)", int'(mag3), 125);
    en3 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
